// File: rtl/port_uart_tx.sv
// port_uart_tx: watches the 4-bit output port, queues every change in a small
// FIFO and sends each queued nibble as one 8N1 UART frame carrying the byte
// {4'b0011, nibble}, so that values 0-9 show up as ASCII digits on a terminal.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   in_port        nibble from the system's port_output
//   in_enable      change-capture enable
//   out_tx         UART line, idle high (registered)
//   out_busy       frame in flight or FIFO non-empty (registered)
//   out_overflow   sticky: a change was dropped because the FIFO was full
//   out_fifo_count current FIFO occupancy
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    in_port,
    input  logic                          in_enable,
    output logic                          out_tx,
    output logic                          out_busy,
    output logic                          out_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ovf_q;
    logic [3:0]        ref_q;

    logic [3:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pop_c;
    logic              change_c;
    logic              push_ok_c;
    logic              ovf_set_c;
    logic              baud_last_c;
    logic              fifo_nonempty_c;

    assign baud_last_c     = (baud_q == BAUD_LAST);
    assign fifo_nonempty_c = (count_q != '0);

    // Transmit FSM: next state, shifter, baud counter and next line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (fifo_nonempty_c) begin
                    pop_c   = 1'b1;
                    shift_d = {4'b0011, mem[rd_ptr_q]};
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_last_c) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (fifo_nonempty_c) begin
                        pop_c   = 1'b1;
                        shift_d = {4'b0011, mem[rd_ptr_q]};
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Change detection and FIFO bookkeeping; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        change_c  = in_enable && (in_port != ref_q);
        push_ok_c = change_c && ((count_q != CNT_FULL) || pop_c);
        ovf_set_c = change_c && (count_q == CNT_FULL) && !pop_c;
        count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        busy_d    = (state_d != S_IDLE) || (count_d != '0);
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ref_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_q | ovf_set_c;
            count_q <= count_d;
            // Reference follows every seen change, even a dropped one, so no retry.
            if (change_c) begin
                ref_q <= in_port;
            end
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr_q] <= in_port;
        end
    end

    assign out_tx         = tx_q;
    assign out_busy       = busy_q;
    assign out_overflow   = ovf_q;
    assign out_fifo_count = count_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Testbench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven 1 time unit after a falling edge; outputs are sampled on
// falling edges. A line monitor decodes every UART frame into a queue.
module tb_port_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_port;
    logic       in_enable;
    logic       out_tx;
    logic       out_busy;
    logic       out_overflow;
    logic [2:0] out_fifo_count;

    port_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_port        (in_port),
        .in_enable      (in_enable),
        .out_tx         (out_tx),
        .out_busy       (out_busy),
        .out_overflow   (out_overflow),
        .out_fifo_count (out_fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Frame monitor: start bit detected on a falling edge, then 10*C samples.
    typedef struct {
        logic [7:0] b;
        int         start;
        logic       good;
    } frame_t;

    frame_t     frames[$];
    logic       in_frame = 1'b0;
    int         fidx;
    int         fstart;
    int         seg;
    int         pos;
    logic [7:0] fbyte;
    logic       fgood;
    int         cnt_max = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (out_tx == 1'b0) begin
                in_frame = 1'b1;
                fidx     = 0;
                fgood    = 1'b1;
                fstart   = cyc;
                fbyte    = '0;
            end
        end else begin
            fidx++;
            seg = fidx / C;
            pos = fidx % C;
            if (seg == 9) begin
                if (out_tx !== 1'b1) fgood = 1'b0;
            end else if (seg == 0) begin
                if (out_tx !== 1'b0) fgood = 1'b0;
            end else if (pos == 0) begin
                fbyte[seg-1] = out_tx;
            end else if (out_tx !== fbyte[seg-1]) begin
                fgood = 1'b0;
            end
            if (fidx == 10*C - 1) begin
                frames.push_back('{fbyte, fstart, fgood});
                in_frame = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (int'(out_fifo_count) > cnt_max) cnt_max = int'(out_fifo_count);
    end

    typedef struct {
        logic       en;
        logic [3:0] port;
        logic       frame;
        logic [7:0] exp_byte;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1; in_enable = 1'b0; in_port = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0; in_enable = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int c0;
    int s;

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 4'h9, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 4'h0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 4'h9, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 4'h9, 1'b1, 8'h39};
        vecs[5]  = '{1'b1, 4'h5, 1'b1, 8'h35};
        vecs[6]  = '{1'b1, 4'h5, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 4'h0, 1'b1, 8'h30};
        vecs[8]  = '{1'b1, 4'hA, 1'b1, 8'h3A};
        vecs[9]  = '{1'b1, 4'hF, 1'b1, 8'h3F};
        vecs[10] = '{1'b0, 4'h1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 4'h1, 1'b1, 8'h31};

        rst = 1'b1; in_enable = 1'b0; in_port = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_tx",       32'(out_tx),         1);
        check("reset_busy",     32'(out_busy),       0);
        check("reset_overflow", 32'(out_overflow),   0);
        check("reset_count",    32'(out_fifo_count), 0);
        #1 rst = 1'b0;

        // Single changes, disabled toggles and no-change cases.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            frames.delete();
            c0 = cyc;
            #1 in_enable = vecs[i].en; in_port = vecs[i].port;
            @(negedge clk);
            check($sformatf("vec%0d_count_e0", i), 32'(out_fifo_count), vecs[i].frame ? 1 : 0);
            check($sformatf("vec%0d_busy_e0", i),  32'(out_busy), 32'(vecs[i].frame));
            if (vecs[i].frame) begin
                check($sformatf("vec%0d_tx_e0", i), 32'(out_tx), 1);
                wait_until(c0 + 2 + 10*C);
                check($sformatf("vec%0d_nframes", i), 32'(frames.size()), 1);
                if (frames.size() > 0) begin
                    check($sformatf("vec%0d_byte", i),  32'(frames[0].b), 32'(vecs[i].exp_byte));
                    check($sformatf("vec%0d_start", i), 32'(frames[0].start), 32'(c0 + 2));
                    check($sformatf("vec%0d_shape", i), 32'(frames[0].good), 1);
                end
                check($sformatf("vec%0d_busy_end", i), 32'(out_busy), 0);
                check($sformatf("vec%0d_tx_end", i),   32'(out_tx), 1);
            end else begin
                wait_until(c0 + 1 + 3*C);
                check($sformatf("vec%0d_noframe", i), 32'(frames.size()), 0);
                check($sformatf("vec%0d_count", i),   32'(out_fifo_count), 0);
                check($sformatf("vec%0d_tx", i),      32'(out_tx), 1);
            end
        end

        // Back-to-back frames from changes on consecutive cycles.
        do_reset();
        @(negedge clk);
        frames.delete();
        cnt_max = 0;
        c0 = cyc;
        #1 in_port = 4'h1;
        @(negedge clk); check("b2b_count_e0", 32'(out_fifo_count), 1);
        #1 in_port = 4'h2;
        @(negedge clk); check("b2b_count_e1", 32'(out_fifo_count), 1);
        #1 in_port = 4'h3;
        @(negedge clk); check("b2b_count_e2", 32'(out_fifo_count), 2);
        wait_until(c0 + 2 + 30*C);
        check("b2b_nframes", 32'(frames.size()), 3);
        for (int k = 0; k < 3 && k < frames.size(); k++) begin
            check($sformatf("b2b_byte%0d", k),  32'(frames[k].b), 32'(8'h31 + k));
            check($sformatf("b2b_start%0d", k), 32'(frames[k].start), 32'(c0 + 2 + 10*C*k));
            check($sformatf("b2b_shape%0d", k), 32'(frames[k].good), 1);
        end
        check("b2b_count_peak", 32'(cnt_max), 2);
        check("b2b_busy_end",   32'(out_busy), 0);

        // Overflow: six changes on consecutive cycles, the sixth is dropped.
        do_reset();
        @(negedge clk);
        frames.delete();
        c0 = cyc;
        for (int v = 1; v <= 6; v++) begin
            #1 in_port = 4'(v);
            @(negedge clk);
            check($sformatf("ovf_count_v%0d", v), 32'(out_fifo_count), (v < 3) ? 1 : ((v > 4) ? 4 : v - 1));
            check($sformatf("ovf_flag_v%0d", v),  32'(out_overflow), (v == 6) ? 1 : 0);
        end
        wait_until(c0 + 2 + 60*C);
        check("ovf_nframes", 32'(frames.size()), 5);
        for (int k = 0; k < 5 && k < frames.size(); k++) begin
            check($sformatf("ovf_byte%0d", k),  32'(frames[k].b), 32'(8'h31 + k));
            check($sformatf("ovf_start%0d", k), 32'(frames[k].start), 32'(c0 + 2 + 10*C*k));
        end
        check("ovf_sticky", 32'(out_overflow),   1);
        check("ovf_count",  32'(out_fifo_count), 0);
        check("ovf_busy",   32'(out_busy),       0);

        // Full FIFO: a change on the final stop-bit edge is accepted by the pop.
        do_reset();
        @(negedge clk);
        frames.delete();
        c0 = cyc;
        for (int v = 1; v <= 5; v++) begin
            #1 in_port = 4'(v);
            @(negedge clk);
        end
        check("full_count_filled", 32'(out_fifo_count), 4);
        wait_until(c0 + 1 + 10*C);
        check("full_count_pre", 32'(out_fifo_count), 4);
        check("full_tx_stop",   32'(out_tx),         1);
        #1 in_port = 4'h7;
        @(negedge clk);
        check("full_count_post", 32'(out_fifo_count), 4);
        check("full_overflow",   32'(out_overflow),   0);
        check("full_tx_start2",  32'(out_tx),         0);
        wait_until(c0 + 2 + 70*C);
        check("full_nframes", 32'(frames.size()), 6);
        if (frames.size() == 6) begin
            check("full_byte4",  32'(frames[4].b),     32'(8'h35));
            check("full_byte5",  32'(frames[5].b),     32'(8'h37));
            check("full_start5", 32'(frames[5].start), 32'(c0 + 2 + 50*C));
        end
        check("full_overflow_end", 32'(out_overflow), 0);

        // Reset during data bit 3 with two entries queued.
        do_reset();
        @(negedge clk);
        frames.delete();
        c0 = cyc;
        #1 in_port = 4'h1;
        @(negedge clk);
        #1 in_port = 4'h2;
        @(negedge clk);
        #1 in_port = 4'h3;
        @(negedge clk);
        s = c0 + 2;
        wait_until(s + 4*C + 1);
        check("rst_count_pre", 32'(out_fifo_count), 2);
        check("rst_tx_bit3",   32'(out_tx),         0);
        #1 rst = 1'b1; in_enable = 1'b0;
        @(negedge clk);
        check("rst_tx",    32'(out_tx),         1);
        check("rst_count", 32'(out_fifo_count), 0);
        check("rst_busy",  32'(out_busy),       0);
        #1 rst = 1'b0;
        c0 = cyc;
        wait_until(c0 + 30*C);
        check("rst_noframe",  32'(frames.size()), 0);
        check("rst_tx_after", 32'(out_tx),         1);
        check("rst_busy_after", 32'(out_busy),     0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
